// File: rtl/pipe_reg_mux.sv
// Enable-gated WIDTH x DEPTH register chain with runtime tap select (0 = bypass)
// and a settle counter that reports when the chosen tap holds a coherent stream.
module pipe_reg_mux #(
  parameter int          WIDTH   = 18,
  parameter int          DEPTH   = 2,
  parameter logic [47:0] RST_VAL = '0,
  localparam int         TW      = (DEPTH + 1 <= 2) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             primed
);

  localparam logic [WIDTH-1:0] RST_WORD  = RST_VAL[WIDTH-1:0];
  localparam logic [TW-1:0]    DEPTH_TAP = TW'(DEPTH);

  logic [WIDTH-1:0] stage_reg [1:DEPTH];
  logic             vstage_reg [1:DEPTH];
  logic [TW-1:0]    tap_reg;
  logic [TW-1:0]    cnt_reg;
  logic [TW-1:0]    eff;
  logic             q_valid_raw;

  // Out-of-range selects clamp silently to the deepest stage.
  always_comb begin
    eff = (tap_sel > DEPTH_TAP) ? DEPTH_TAP : tap_sel;
  end

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
      if (gi == 1) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_reg[gi]  <= RST_WORD;
            vstage_reg[gi] <= 1'b0;
          end else if (clk_en) begin
            stage_reg[gi]  <= d;
            vstage_reg[gi] <= d_valid;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_reg[gi]  <= RST_WORD;
            vstage_reg[gi] <= 1'b0;
          end else if (clk_en) begin
            stage_reg[gi]  <= stage_reg[gi-1];
            vstage_reg[gi] <= vstage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // A tap change restarts the fill count; stage contents are left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      tap_reg <= eff;
    end else if (clk_en) begin
      if (eff != tap_reg) begin
        cnt_reg <= '0;
        tap_reg <= eff;
      end else if (cnt_reg < eff) begin
        cnt_reg <= cnt_reg + TW'(1);
      end
    end
  end

  always_comb begin
    q           = d;
    q_valid_raw = d_valid;
    for (int k = 1; k <= DEPTH; k++) begin
      if (eff == TW'(k)) begin
        q           = stage_reg[k];
        q_valid_raw = vstage_reg[k];
      end
    end
  end

  assign primed  = (eff == tap_reg) && (cnt_reg >= eff);
  assign q_valid = q_valid_raw && primed;

endmodule

// File: tb/tb_pipe_reg_mux.sv
// Directed checks of pipe_reg_mux: a DEPTH=4 instance for latency, bypass, hold,
// tap change and mid-stream reset; a DEPTH=2 instance for clamping and reset priority.
module tb_pipe_reg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH=4, WIDTH=18, RST_VAL=0
  logic        a_rst = 1'b1, a_en = 1'b1, a_dv = 1'b0;
  logic [17:0] a_d = '0;
  logic [2:0]  a_tap = 3'd3;
  logic [17:0] a_q;
  logic        a_qv, a_pr;

  pipe_reg_mux #(.WIDTH(18), .DEPTH(4), .RST_VAL(48'h0)) dut_a (
    .clk(clk), .rst(a_rst), .clk_en(a_en), .d(a_d), .d_valid(a_dv),
    .tap_sel(a_tap), .q(a_q), .q_valid(a_qv), .primed(a_pr)
  );

  // Instance B: DEPTH=2, WIDTH=18, RST_VAL=3FFFF
  logic        b_rst = 1'b1, b_en = 1'b0, b_dv = 1'b0;
  logic [17:0] b_d = '0;
  logic [1:0]  b_tap = 2'd3;
  logic [17:0] b_q;
  logic        b_qv, b_pr;

  pipe_reg_mux #(.WIDTH(18), .DEPTH(2), .RST_VAL(48'h3FFFF)) dut_b (
    .clk(clk), .rst(b_rst), .clk_en(b_en), .d(b_d), .d_valid(b_dv),
    .tap_sel(b_tap), .q(b_q), .q_valid(b_qv), .primed(b_pr)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chk3(input string tag, input int eq, input int ev, input int ep,
                      input logic [17:0] q, input logic qv, input logic pr);
    chk({tag, "_q"}, 48'(q), 48'(eq));
    chk({tag, "_qv"}, 48'(qv), 48'(ev));
    chk({tag, "_pr"}, 48'(pr), 48'(ep));
  endtask

  initial begin
    int hold_q;
    // ---------- latency sweep, tap 3 held from reset ----------
    tick();
    $display("reset A tap3: q=%h qv=%b pr=%b", a_q, a_qv, a_pr);
    chk3("rst_a", 0, 0, 0, a_q, a_qv, a_pr);
    a_rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a_d = 18'(i); a_dv = 1'b1;
      tick();
      $display("lat edge %0d: d=%0d q=%0d qv=%b pr=%b", i, i, a_q, a_qv, a_pr);
      chk3("lat", (i >= 3) ? i - 2 : 0, (i >= 3) ? 1 : 0, (i >= 3) ? 1 : 0, a_q, a_qv, a_pr);
    end

    // ---------- tap change 3 -> 1 -> 4 on a continuous stream ----------
    a_tap = 3'd1; a_d = 18'd9;
    #1;
    chk("tap1_pre_pr", 48'(a_pr), 48'd0);
    for (int i = 9; i <= 12; i++) begin
      a_d = 18'(i);
      tick();
      $display("tap1 edge d=%0d: q=%0d qv=%b pr=%b", i, a_q, a_qv, a_pr);
      chk3("tap1", i, (i - 8 >= 2) ? 1 : 0, (i - 8 >= 2) ? 1 : 0, a_q, a_qv, a_pr);
    end
    a_tap = 3'd4; a_d = 18'd13;
    #1;
    chk("tap4_pre_pr", 48'(a_pr), 48'd0);
    for (int i = 13; i <= 20; i++) begin
      a_d = 18'(i);
      tick();
      $display("tap4 edge d=%0d: q=%0d qv=%b pr=%b", i, a_q, a_qv, a_pr);
      chk3("tap4", i - 3, (i - 12 >= 5) ? 1 : 0, (i - 12 >= 5) ? 1 : 0, a_q, a_qv, a_pr);
    end

    // ---------- reset mid-stream at tap 3 ----------
    a_tap = 3'd3; a_rst = 1'b1; a_d = 18'd21;
    tick();
    $display("midrst: q=%0d qv=%b pr=%b", a_q, a_qv, a_pr);
    chk3("midrst", 0, 0, 0, a_q, a_qv, a_pr);
    a_rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      a_d = 18'(100 + j);
      tick();
      $display("post-rst edge %0d: d=%0d q=%0d qv=%b pr=%b", j, 100 + j, a_q, a_qv, a_pr);
      chk3("postrst", (j >= 3) ? 98 + j : 0, (j >= 3) ? 1 : 0, (j >= 3) ? 1 : 0, a_q, a_qv, a_pr);
    end

    // ---------- clock-enable hold at tap 2 ----------
    a_tap = 3'd2; a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      a_d = 18'(i);
      tick();
      $display("hold fill d=%0d: q=%0d qv=%b pr=%b", i, a_q, a_qv, a_pr);
      chk3("hfill", (i >= 11) ? i - 1 : 0, (i >= 11) ? 1 : 0, (i >= 11) ? 1 : 0, a_q, a_qv, a_pr);
    end
    a_en = 1'b0;
    hold_q = 11;
    for (int c = 0; c < 5; c++) begin
      a_d = 18'($urandom); a_dv = 1'($urandom);
      tick();
      $display("hold cycle %0d: q=%0d qv=%b pr=%b", c, a_q, a_qv, a_pr);
      chk3("hold", hold_q, 1, 1, a_q, a_qv, a_pr);
    end
    a_en = 1'b1; a_dv = 1'b1;
    for (int i = 13; i <= 14; i++) begin
      a_d = 18'(i);
      tick();
      $display("resume d=%0d: q=%0d qv=%b pr=%b", i, a_q, a_qv, a_pr);
      chk3("resume", i - 1, 1, 1, a_q, a_qv, a_pr);
    end

    // ---------- tap change while disabled: detected on next enabled edge ----------
    a_en = 1'b0; a_tap = 3'd1; a_d = 18'd77;
    tick();
    $display("tapchg disabled: q=%0d qv=%b pr=%b", a_q, a_qv, a_pr);
    chk3("tapdis", 14, 0, 0, a_q, a_qv, a_pr);
    a_en = 1'b1; a_d = 18'd15;
    tick();
    chk3("tapen1", 15, 0, 0, a_q, a_qv, a_pr);
    a_d = 18'd16;
    tick();
    $display("tapchg enabled: q=%0d qv=%b pr=%b", a_q, a_qv, a_pr);
    chk3("tapen2", 16, 1, 1, a_q, a_qv, a_pr);

    // ---------- bypass, tap 0 ----------
    a_tap = 3'd0; a_rst = 1'b1; a_dv = 1'b0;
    tick();
    a_rst = 1'b0;
    chk("byp_rst_pr", 48'(a_pr), 48'd1);
    a_d = 18'h2A5A5; a_dv = 1'b1;
    #1;
    $display("bypass: d=%h q=%h qv=%b pr=%b", a_d, a_q, a_qv, a_pr);
    chk3("byp1", 'h2A5A5, 1, 1, a_q, a_qv, a_pr);
    a_dv = 1'b0;
    #1;
    chk("byp_qv_low", 48'(a_qv), 48'd0);
    tick();
    a_d = 18'h12345; a_dv = 1'b1;
    #1;
    $display("bypass: d=%h q=%h qv=%b pr=%b", a_d, a_q, a_qv, a_pr);
    chk3("byp2", 'h12345, 1, 1, a_q, a_qv, a_pr);

    // ---------- instance B: clamp tap 3 -> 2, RST_VAL 3FFFF ----------
    b_en = 1'b1;
    tick();
    $display("reset B: q=%h qv=%b pr=%b", b_q, b_qv, b_pr);
    chk3("rst_b", 'h3FFFF, 0, 0, b_q, b_qv, b_pr);
    b_rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b_d = 18'(i); b_dv = 1'b1;
      tick();
      $display("clamp edge %0d: q=%h qv=%b pr=%b", i, b_q, b_qv, b_pr);
      chk3("clamp", (i >= 2) ? i - 1 : 'h3FFFF, (i >= 2) ? 1 : 0, (i >= 2) ? 1 : 0,
           b_q, b_qv, b_pr);
    end
    // reset takes effect with clk_en low
    b_en = 1'b0; b_rst = 1'b1; b_d = 18'd55;
    tick();
    $display("rst w/o en: q=%h qv=%b pr=%b", b_q, b_qv, b_pr);
    chk3("rstprio", 'h3FFFF, 0, 0, b_q, b_qv, b_pr);
    b_rst = 1'b0;
    tick();
    chk3("rstprio_hold", 'h3FFFF, 0, 0, b_q, b_qv, b_pr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
